// File: rtl/ahb_regslave.sv
// AHB-lite register slave: ID word, NREG-1 read/write registers, doorbell irq,
// programmable OKAY wait states and the two-cycle ERROR response.
module ahb_regslave #(
    parameter int          NREG     = 8,
    parameter int          AW       = 4,
    parameter int          WAIT_CYC = 0,
    parameter logic [31:0] ID_VAL   = 32'hC0FFEE01
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        irq_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          wr_q, wr_d;
    logic          irq_q, irq_d;
    logic [31:0]   regs_q [1:NREG-1];
    logic [31:0]   regs_d [1:NREG-1];

    logic [AW-1:0] idx_a;
    logic          accept, err_a;
    logic [3:0]    be;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign unused_bits = ^{haddr[31:AW+2], htrans[0]};

    assign hreadyout = !(state_q == S_WAIT || state_q == S_ERR1);
    assign hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
    assign hrdata    = (state_q == S_XFER) ? rd_val : 32'h0;
    assign irq_o     = irq_q;

    // A new address phase is only taken while this slave is not stalling the bus.
    assign idx_a  = haddr[AW+1:2];
    assign accept = hsel & hready & htrans[1] & hreadyout;
    assign err_a  = (32'(idx_a) >= NREG) || (hsize > 3'd2)
                 || (hsize == 3'd1 && haddr[0])
                 || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                 || (hwrite && idx_a == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        wr_d    = wr_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = S_XFER;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d  = idx_a;
                    off_d  = haddr[1:0];
                    size_d = hsize[1:0];
                    wr_d   = hwrite;
                    if (err_a) begin
                        state_d = S_ERR1;
                    end else if (WAIT_CYC > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 3'(WAIT_CYC - 1);
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << off_q;
            2'd1:    be = 4'b0011 << off_q;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (state_q == S_XFER && wr_q) begin
            for (int i = 1; i < NREG; i++) begin
                if (idx_q == AW'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) regs_d[i][8*b +: 8] = hwdata[8*b +: 8];
                    end
                end
            end
        end
        irq_d = |regs_d[NREG-1];
    end

    // Index 0 never matches the loop, so it falls through to the ID word.
    always_comb begin
        rd_val = ID_VAL;
        for (int i = 1; i < NREG; i++) begin
            if (idx_q == AW'(i)) rd_val = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            irq_q   <= 1'b0;
            for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            irq_q   <= irq_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_ahb_regslave.sv
// Bench for ahb_regslave: two instances (0 and 3 wait states) behind a slave mux,
// pipelined AHB master driving directed and random transfers against a word-level model.
module tb_ahb_regslave;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel_m, dsel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic        hro0, hresp0, irq0, hro3, hresp3, irq3;
    logic [31:0] hrdata0, hrdata3;

    always #5 clk = ~clk;

    assign hready = dsel ? hro3 : hro0;

    ahb_regslave #(.WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .hsel(hsel_m & ~dsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0), .irq_o(irq0));

    ahb_regslave #(.WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .hsel(hsel_m & dsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hro3), .hresp(hresp3), .hrdata(hrdata3), .irq_o(irq3));

    typedef struct {
        bit          idle;
        bit          busy;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q[$];
    bit   [31:0] mdl [0:1][0:7];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int d = 0; d < 2; d++) begin
            mdl[d][0] = 32'hC0FFEE01;
            for (int i = 1; i < 8; i++) mdl[d][i] = 0;
        end
    endtask

    function automatic bit mdl_err(input bit wr, input logic [31:0] a, input logic [2:0] sz);
        int idx;
        idx = int'(a[5:2]);
        return (idx >= 8) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
               (sz == 3'd2 && a[1:0] != 2'b00) || (wr && idx == 0);
    endfunction

    task automatic mdl_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
        int idx, off, n;
        idx = int'(a[5:2]);
        off = int'(a[1:0]);
        n   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        if (n == 4) off = 0;
        for (int k = off; k < off + n; k++) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
    endtask

    function automatic txn_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                input logic [31:0] wd);
        txn_t t;
        t.idle = 0; t.busy = 0; t.wr = wr; t.addr = a; t.size = sz; t.wdata = wd;
        return t;
    endfunction

    function automatic txn_t mk_idle(input bit busy);
        txn_t t;
        t = mk(1'b1, 32'h1C, 3'd2, 32'h0);
        t.idle = 1; t.busy = busy;
        return t;
    endfunction

    // Entered and left at posedge+1; runs the queue as a pipelined master.
    task automatic run_q(input int d);
        txn_t        dp, t;
        bit          dpv, e, ro, rs, wresp;
        logic [31:0] rd;
        int          waits, cyc;
        dpv = 0; waits = 0; wresp = 0; cyc = 0;
        dsel = (d != 0);
        while ((q.size() > 0 || dpv) && cyc < 3000) begin
            if (q.size() > 0 && !q[0].idle) begin
                hsel_m = 1; htrans = 2'b10; hwrite = q[0].wr; haddr = q[0].addr; hsize = q[0].size;
            end else if (q.size() > 0) begin
                hsel_m = 1'($urandom); htrans = q[0].busy ? 2'b01 : 2'b00;
                hwrite = 1; haddr = q[0].addr; hsize = q[0].size;
            end else begin
                hsel_m = 0; htrans = 2'b00;
            end
            hwdata = (dpv && dp.wr) ? dp.wdata : $urandom;
            @(negedge clk);
            chk("irq0", irq0, |mdl[0][7]);
            chk("irq3", irq3, |mdl[1][7]);
            ro = d ? hro3 : hro0;
            rs = d ? hresp3 : hresp0;
            rd = d ? hrdata3 : hrdata0;
            if (!ro) begin
                waits++;
                wresp |= rs;
                chk("wait_rdata", rd, 0);
            end else if (dpv) begin
                e = mdl_err(dp.wr, dp.addr, dp.size);
                chk("resp", 32'(rs), 32'(e));
                chk("waits", 32'(waits), e ? 1 : (d ? 3 : 0));
                chk("wait_resp", 32'(wresp), 32'(e));
                if (!e && !dp.wr) chk("rdata", rd, mdl[d][dp.addr[4:2]]);
                if (!e && dp.wr) mdl_write(d, dp.addr, dp.size, dp.wdata);
            end else begin
                chk("idle_rdata", rd, 0);
                chk("idle_resp", 32'(rs), 0);
            end
            @(posedge clk);
            #1;
            if (ro) begin
                dpv = 0;
                if (q.size() > 0) begin
                    t = q.pop_front();
                    if (!t.idle) begin
                        dp = t; dpv = 1; waits = 0; wresp = 0;
                    end
                end
            end
            cyc++;
        end
        chk("drained", 32'(q.size()) + 32'(dpv), 0);
        q.delete();
        hsel_m = 0; htrans = 2'b00;
    endtask

    task automatic push_rand(input int n);
        int idx, off, sz;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                q.push_back(mk_idle(1'($urandom)));
            end else begin
                idx = $urandom_range(0, 9);
                off = $urandom_range(0, 3);
                sz  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2) off = 0;
                    if (sz == 1) off = off & 2;
                end
                q.push_back(mk(1'($urandom), ($urandom & 32'hFFFF_FFC0) | 32'(idx << 2) | 32'(off),
                               3'(sz), $urandom));
            end
        end
    endtask

    task automatic push_errs();
        q.push_back(mk(1, 32'h00, 3'd2, 32'h1111_1111));
        q.push_back(mk(0, 32'h20, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h06, 3'd2, 32'h2222_2222));
        q.push_back(mk(0, 32'h04, 3'd3, 32'h0));
        q.push_back(mk(0, 32'h04, 3'd2, 32'h0));
        q.push_back(mk(0, 32'h00, 3'd2, 32'h0));
    endtask

    initial begin
        rstn = 0; hsel_m = 0; dsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0; hwdata = 0;
        mdl_reset();
        #12;
        chk("rst_hro0", hro0, 1);  chk("rst_hresp0", hresp0, 0);
        chk("rst_hrdata0", hrdata0, 0); chk("rst_irq0", irq0, 0);
        chk("rst_hro3", hro3, 1);  chk("rst_hresp3", hresp3, 0);
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;

        // zero-wait instance: back-to-back write/read, lane merging, errors, doorbell
        q.push_back(mk(1, 32'h04, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(0, 32'h04, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h08, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h08, 3'd0, 32'h0000_0011));
        q.push_back(mk(1, 32'h0B, 3'd0, 32'hAA00_0000));
        q.push_back(mk_idle(1));
        q.push_back(mk(1, 32'h0A, 3'd1, 32'h5566_0000));
        q.push_back(mk(0, 32'h08, 3'd2, 32'h0));
        push_errs();
        q.push_back(mk(1, 32'h1C, 3'd2, 32'h1));
        q.push_back(mk(1, 32'h1C, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h1C, 3'd2, 32'h1));
        q.push_back(mk(1, 32'h1D, 3'd0, 32'h0));
        q.push_back(mk_idle(0));
        q.push_back(mk(0, 32'h1C, 3'd2, 32'h0));
        run_q(0);
        chk("lane_merge", mdl[0][2], 32'h5566_0011);
        push_rand(200);
        run_q(0);

        // three-wait instance: ID read, errors stay two cycles, random traffic
        q.push_back(mk(0, 32'h00, 3'd2, 32'h0));
        push_errs();
        push_rand(120);
        q.push_back(mk(1, 32'h1C, 3'd2, 32'h1));
        run_q(1);

        // reset during the wait states of a write
        hsel_m = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h0C; hsize = 3'd2;
        @(posedge clk); #1;
        hsel_m = 0; htrans = 2'b00; hwdata = 32'h1234_5678;
        @(negedge clk);
        chk("pre_rst_wait", hro3, 0);
        #2 rstn = 0;
        #1;
        chk("mid_rst_hro", hro3, 1);
        chk("mid_rst_hresp", hresp3, 0);
        chk("mid_rst_hrdata", hrdata3, 0);
        chk("mid_rst_irq", irq3, 0);
        mdl_reset();
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
        q.push_back(mk(0, 32'h0C, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h0C, 3'd2, 32'hA5A5_5A5A));
        q.push_back(mk(0, 32'h0C, 3'd2, 32'h0));
        run_q(1);
        chk("post_rst_reg", mdl[1][3], 32'hA5A5_5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
